// File: rtl/ibex_bloom_ctrl.sv
// ibex_bloom_ctrl: sequencer for Bloom-filter INSERT/CHECK/CLEAR ops on a single-port filter RAM
module ibex_bloom_ctrl #(
   parameter int unsigned Depth   = 64,
   parameter int unsigned NumHash = 3,
   parameter int unsigned CntW    = 16,
   localparam int unsigned AW     = $clog2(Depth)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            custom_en_i,
   input  logic [4:0]      custom_op_i,
   input  logic [31:0]     custom_rs1_i,
   input  logic [31:0]     custom_rs2_i,
   input  logic            custom_ready_id_i,
   input  logic            custom_kill_i,
   output logic            custom_valid_o,
   output logic [31:0]     custom_result_o,
   output logic            custom_illegal_o,
   output logic            custom_busy_o,
   output logic [CntW-1:0] insert_cnt_o,
   output logic            ram_req_o,
   output logic            ram_we_o,
   output logic [AW-1:0]   ram_addr_o,
   output logic [31:0]     ram_wdata_o,
   input  logic [31:0]     ram_rdata_i
);
   localparam int unsigned IW = AW + 5;
   typedef enum logic [2:0] {IDLE, READ, EVAL, CLR, DONE} state_e;
   state_e          state;
   logic [IW-1:0]   idx, step;
   logic [3:0]      k;
   logic            hit, illegal, is_ins, is_chk;
   logic [AW-1:0]   clr_addr;
   logic [CntW-1:0] cnt;
   logic            probe_bit, wr, unused_bits;
   assign unused_bits = ^{custom_rs1_i[31:IW], custom_rs2_i[31:IW]};
   assign probe_bit   = ram_rdata_i[idx[4:0]];
   assign wr          = state == CLR || (state == EVAL && is_ins);
   // a kill squashes whatever access would happen this cycle
   assign ram_req_o   = !custom_kill_i && (wr || state == READ);
   assign ram_we_o    = !custom_kill_i && wr;
   assign ram_addr_o  = state == CLR ? clr_addr : idx[IW-1:5];
   assign ram_wdata_o = state == CLR ? 32'd0 : ram_rdata_i | (32'd1 << idx[4:0]);
   assign custom_valid_o   = state == DONE;
   assign custom_result_o  = {31'd0, hit};
   assign custom_illegal_o = custom_valid_o && illegal;
   assign custom_busy_o    = state != IDLE;
   assign insert_cnt_o     = cnt;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= IDLE;
         idx      <= '0;
         step     <= '0;
         k        <= '0;
         hit      <= 1'b0;
         illegal  <= 1'b0;
         is_ins   <= 1'b0;
         is_chk   <= 1'b0;
         clr_addr <= '0;
         cnt      <= '0;
      end else if (custom_kill_i) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: if (custom_en_i) begin
               idx      <= custom_rs1_i[IW-1:0];
               step     <= custom_rs2_i[IW-1:0] | IW'(1);
               k        <= '0;
               hit      <= custom_op_i < 5'd2;
               illegal  <= custom_op_i > 5'd2;
               is_ins   <= custom_op_i == 5'd0;
               is_chk   <= custom_op_i == 5'd1;
               clr_addr <= '0;
               state    <= custom_op_i < 5'd2 ? READ : custom_op_i == 5'd2 ? CLR : DONE;
            end
            READ: state <= EVAL;
            EVAL: begin
               hit <= hit & probe_bit;
               if (is_chk && !probe_bit) state <= DONE;
               else begin
                  idx   <= idx + step;
                  k     <= k + 4'd1;
                  state <= k == 4'(NumHash - 1) ? DONE : READ;
               end
            end
            CLR: begin
               clr_addr <= clr_addr + AW'(1);
               if (clr_addr == AW'(Depth - 1)) begin
                  state <= DONE;
                  cnt   <= '0;
               end
            end
            DONE: if (custom_ready_id_i) begin
               state <= IDLE;
               if (is_ins && cnt != '1) cnt <= cnt + CntW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ibex_bloom_ctrl.sv
// tb_ibex_bloom_ctrl: directed plus randomized checks of ibex_bloom_ctrl against a bit-array filter model
module tb_ibex_bloom_ctrl;
   localparam int Depth = 64, NumHash = 3, CntW = 16, AW = 6, M = Depth * 32;
   logic clk = 0, rst_ni = 0;
   logic en = 0, ready = 0, kill = 0;
   logic [4:0] op = 0;
   logic [31:0] rs1 = 0, rs2 = 0;
   logic valid, illegal, busy, req, we;
   logic [31:0] result, wdata, rdata;
   logic [CntW-1:0] cnt;
   logic [AW-1:0] addr;
   logic [31:0] mem [Depth];
   logic ref_f [M];
   int ref_cnt = 0, nvec = 0, nerr = 0;
   int wq_addr[$];
   logic [31:0] wq_data[$];
   logic [63:0] keys[$];
   always #5 clk = ~clk;
   ibex_bloom_ctrl #(.Depth(Depth), .NumHash(NumHash), .CntW(CntW)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .custom_en_i(en), .custom_op_i(op),
      .custom_rs1_i(rs1), .custom_rs2_i(rs2), .custom_ready_id_i(ready),
      .custom_kill_i(kill), .custom_valid_o(valid), .custom_result_o(result),
      .custom_illegal_o(illegal), .custom_busy_o(busy), .insert_cnt_o(cnt),
      .ram_req_o(req), .ram_we_o(we), .ram_addr_o(addr), .ram_wdata_o(wdata),
      .ram_rdata_i(rdata));
   always @(posedge clk) if (req) begin
      if (we) mem[addr] <= wdata;
      else rdata <= mem[addr];
   end
   always @(posedge clk) if (req && we) begin
      wq_addr.push_back(int'(addr));
      wq_data.push_back(wdata);
   end
   always @(negedge clk) if (rst_ni)
      assert (!(req && (!busy || valid))) else begin
         nerr++;
         $error("FAIL req_idle_done: req=%b busy=%b valid=%b, required req=0", req, busy, valid);
      end
   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic res, output logic ill);
      int i, s;
      i = int'(a & (M - 1));
      s = int'(b & (M - 1)) | 1;
      ill = 0;
      res = 0;
      if (o == 0) begin
         res = 1;
         lat = 1 + 2 * NumHash;
         for (int p = 0; p < NumHash; p++) begin
            res &= ref_f[i];
            ref_f[i] = 1;
            i = (i + s) % M;
         end
      end else if (o == 1) begin
         res = 1;
         lat = 1 + 2 * NumHash;
         for (int p = 0; p < NumHash; p++) begin
            if (!ref_f[i]) begin
               res = 0;
               lat = 1 + 2 * (p + 1);
               break;
            end
            i = (i + s) % M;
         end
      end else if (o == 2) begin
         lat = 1 + Depth;
         for (int j = 0; j < M; j++) ref_f[j] = 0;
      end else begin
         lat = 1;
         ill = 1;
      end
   endtask
   task automatic start_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
      wq_addr.delete();
      wq_data.delete();
      @(negedge clk);
      en = 1; op = o; rs1 = a; rs2 = b;
      @(posedge clk); #1;
      en = 0; op = 5'($urandom); rs1 = $urandom; rs2 = $urandom;
   endtask
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!valid && lat < 300) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask
   task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b, input int hold);
      int lat, exp_lat;
      logic exp_res, exp_ill;
      model(o, a, b, exp_lat, exp_res, exp_ill);
      start_op(o, a, b);
      wait_valid(lat);
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("result", result, {31'd0, exp_res});
      chk("illegal", {31'd0, illegal}, {31'd0, exp_ill});
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk("hold_valid", {31'd0, valid}, 32'd1);
         chk("hold_result", result, {31'd0, exp_res});
      end
      ready = 1;
      @(posedge clk); #1;
      ready = 0;
      if (o == 0 && ref_cnt < 65535) ref_cnt++;
      if (o == 2) ref_cnt = 0;
      chk("busy_after", {31'd0, busy}, 32'd0);
      chk("valid_after", {31'd0, valid}, 32'd0);
      chk("insert_cnt", 32'(cnt), 32'(ref_cnt));
   endtask
   task automatic mem_chk(input string tag);
      logic ok;
      ok = 1;
      for (int w = 0; w < Depth; w++)
         for (int b = 0; b < 32; b++)
            if (mem[w][b] !== ref_f[w * 32 + b]) ok = 0;
      chk(tag, {31'd0, ok}, 32'd1);
   endtask
   initial begin
      logic ok;
      int lat, r;
      logic [4:0] o;
      logic [31:0] a, b;
      logic [63:0] kv;
      for (int w = 0; w < Depth; w++) mem[w] = $urandom;
      for (int j = 0; j < M; j++) ref_f[j] = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_cnt", 32'(cnt), 32'd0);
      chk("rst_req", {31'd0, req}, 32'd0);
      chk("rst_result", result, 32'd0);
      @(negedge clk) rst_ni = 1;
      run_op(2, $urandom, $urandom, 0);
      ok = wq_addr.size() == Depth;
      for (int j = 0; j < wq_addr.size(); j++) if (wq_addr[j] != j || wq_data[j] != 0) ok = 0;
      chk("clear_writes", {31'd0, ok}, 32'd1);
      mem_chk("ram_after_clear");
      run_op(0, 32'h25, 32'h40, 0);
      chk("ins1_words", {31'd0, wq_addr.size() == 3 && wq_addr[0] == 1 && wq_addr[1] == 3 && wq_addr[2] == 5}, 32'd1);
      mem_chk("ram_after_ins1");
      run_op(1, 32'h25, 32'h40, 3);
      run_op(1, 32'h26, 32'h40, 0);
      run_op(0, 32'h7FF, 32'h2, 0);
      chk("ins_wrap_words", {31'd0, wq_addr.size() == 3 && wq_addr[0] == 63 && wq_addr[1] == 0 && wq_addr[2] == 0}, 32'd1);
      mem_chk("ram_after_wrap");
      run_op(7, $urandom, $urandom, 0);
      start_op(0, 32'h100, 32'h20);
      repeat (3) @(posedge clk);
      #1;
      wq_addr.delete();
      kill = 1;
      #1;
      chk("kill_req", {31'd0, req}, 32'd0);
      @(posedge clk); #1;
      kill = 0;
      ref_f[32'h100] = 1;
      chk("kill_busy", {31'd0, busy}, 32'd0);
      chk("kill_valid", {31'd0, valid}, 32'd0);
      chk("kill_nowrite", 32'(wq_addr.size()), 32'd0);
      chk("kill_cnt", 32'(cnt), 32'(ref_cnt));
      mem_chk("ram_after_kill");
      model(0, 32'h555, 32'h77, lat, ok, ok);
      start_op(0, 32'h555, 32'h77);
      wait_valid(lat);
      kill = 1; ready = 1;
      @(posedge clk); #1;
      kill = 0; ready = 0;
      chk("kill_ready_busy", {31'd0, busy}, 32'd0);
      chk("kill_ready_cnt", 32'(cnt), 32'(ref_cnt));
      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 9);
         a = $urandom;
         b = $urandom;
         o = r < 4 ? 5'd0 : r < 8 ? 5'd1 : r == 8 ? 5'($urandom_range(3, 31)) : 5'd2;
         if (o == 1 && keys.size() > 0 && $urandom_range(0, 1) == 1) begin
            kv = keys[$urandom_range(0, keys.size() - 1)];
            a = kv[63:32];
            b = kv[31:0];
         end
         if (o == 0) keys.push_back({a, b});
         run_op(o, a, b, $urandom_range(0, 2));
      end
      mem_chk("ram_after_random");
      start_op(0, 32'h300, 32'h5);
      #2 rst_ni = 0;
      #1;
      ref_cnt = 0;
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_req", {31'd0, req}, 32'd0);
      chk("arst_cnt", 32'(cnt), 32'd0);
      @(negedge clk) rst_ni = 1;
      mem_chk("ram_after_arst");
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
